// File: rtl/tt_serial_tx_pkg.sv
// Shared types and constants for the serial transmitter.
// Latency: n/a (package only).
// Backpressure: n/a.
package tt_serial_tx_pkg;

    localparam int BAUD_BASE = 4;
    localparam int DATA_BITS = 8;
    localparam int SEL_W     = 3;
    localparam int TICK_W    = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Last count value of one bit period: (BAUD_BASE << sel) - 1, i.e. 3..511.
    function automatic logic [TICK_W-1:0] period_last(input logic [SEL_W-1:0] sel);
        logic [TICK_W:0] period;
        period = (TICK_W+1)'(BAUD_BASE) << sel;
        return TICK_W'(period - (TICK_W+1)'(1));
    endfunction

endpackage

// File: rtl/tt_serial_tx_if.sv
// Link between the frame FSM and the bit-period generator.
// Latency: wires only.
// Backpressure: none; bit_tick is a one-cycle strobe.
interface tt_serial_tx_if;
    import tt_serial_tx_pkg::*;

    logic             restart;
    logic [SEL_W-1:0] sel;
    logic             bit_tick;

    modport master (output restart, output sel, input bit_tick);
    modport slave  (input restart, input sel, output bit_tick);

endinterface

// File: rtl/serial_tx_baud_gen.sv
// Bit-period counter: strobes bit_tick on the last clock of each (4 << sel) period.
// Latency: first tick on the period-th clock after restart.
// Backpressure: none; free-runs and wraps, restart realigns it to a frame start.
module serial_tx_baud_gen
    import tt_serial_tx_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    tt_serial_tx_if.slave bus
);

    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] last;

    assign last         = period_last(bus.sel);
    assign bus.bit_tick = (cnt == last);

    // Count up within a period; reload at every bit boundary or frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.restart || bus.bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/tt_um_nasser_hadi_serial_tx.sv
// UART-style byte transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Latency: TXD falls 2 clocks after the start edge is first sampled.
// Backpressure: start edges seen while BUSY are dropped, never queued.
module tt_um_nasser_hadi_serial_tx
    import tt_serial_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tt_serial_tx_if baud_bus ();

    serial_tx_baud_gen u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (baud_bus.slave)
    );

    logic                 sync1, sync2, hist;
    logic                 start_det, accept;
    state_t               state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity, pen_cap;
    logic [SEL_W-1:0]     sel_cap;
    logic                 txd, busy, done;
    logic                 unused;

    assign unused    = &{1'b0, ena, uio_in[7:5]};
    assign start_det = sync2 & ~hist;
    assign accept    = (state == IDLE) && start_det;

    assign baud_bus.restart = accept;
    assign baud_bus.sel     = sel_cap;

    assign uo_out  = {5'b0, done, busy, txd};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Two-flop synchronizer plus history flop; reset high so a held start is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= uio_in[0];
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Frame FSM with registered TXD/BUSY/DONE; frame parameters frozen at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            pen_cap <= 1'b0;
            sel_cap <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state   <= START;
                        shreg   <= ui_in;
                        parity  <= ^ui_in;
                        sel_cap <= uio_in[3:1];
                        pen_cap <= uio_in[4];
                        bit_cnt <= '0;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_bus.bit_tick) begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_bus.bit_tick) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            if (pen_cap) begin
                                state <= PARITY;
                                txd   <= parity;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            shreg <= shreg >> 1;
                            txd   <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_bus.bit_tick) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_bus.bit_tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_nasser_hadi_serial_tx.sv
// Directed bench for the serial transmitter: frame table plus hand-written corner sequences.
module tb_tt_um_nasser_hadi_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_um_nasser_hadi_serial_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [7:0]  d;
        logic [2:0]  sel;
        logic        pen;
        logic [10:0] exp_bits;   // TXD per bit period, period 0 in bit 0
        int          nbits;
        int          raise_at;   // cycle after acceptance to re-raise start, -1 = never
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise start with the given frame parameters; returns at the acceptance edge.
    task automatic start_frame(input logic [7:0] d, input logic [2:0] sel, input logic pen);
        @(negedge clk);
        ui_in  = d;
        uio_in = {3'b000, pen, sel, 1'b1};
        repeat (3) @(posedge clk);
    endtask

    // Check every cycle of a frame from the acceptance edge, then the DONE cycle.
    task automatic check_frame(input string tag, input logic [10:0] exp_bits, input int nbits,
                               input logic [2:0] sel, input int raise_at);
        int   per;
        int   cyc;
        int   errs;
        logic got;
        per  = 4 << sel;
        cyc  = 0;
        errs = 0;
        for (int i = 0; i < nbits; i++) begin
            got = exp_bits[i];
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (uo_out[0] !== exp_bits[i]) got = uo_out[0];
                if (uo_out[1] !== 1'b1 || uo_out[2] !== 1'b0) errs++;
                if (cyc == 0) begin
                    ui_in       = 8'h00;
                    uio_in[4:1] = ~uio_in[4:1];
                end
                if (cyc == 2) uio_in[0] = 1'b0;
                if (cyc == raise_at) uio_in[0] = 1'b1;
                cyc++;
            end
            chk($sformatf("%s txd period %0d", tag, i), 32'(got), 32'(exp_bits[i]));
        end
        chk($sformatf("%s busy/done in frame", tag), errs, 0);
        @(negedge clk);
        chk($sformatf("%s done/busy/txd at end", tag), 32'(uo_out[2:0]), 32'h5);
    endtask

    initial begin
        int errs;

        vecs[0] = '{8'hA5, 3'd0, 1'b0, 11'h34A, 10, -1};
        vecs[1] = '{8'h07, 3'd1, 1'b1, 11'h60E, 11, -1};
        vecs[2] = '{8'hA5, 3'd1, 1'b1, 11'h54A, 11, -1};
        vecs[3] = '{8'h3C, 3'd2, 1'b0, 11'h278, 10, -1};
        vecs[4] = '{8'hFF, 3'd0, 1'b1, 11'h5FE, 11, -1};
        vecs[5] = '{8'h00, 3'd0, 1'b1, 11'h400, 11, -1};
        vecs[6] = '{8'hA5, 3'd0, 1'b0, 11'h34A, 10, 20};
        vecs[7] = '{8'hA5, 3'd7, 1'b0, 11'h34A, 10, -1};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset uo_out", 32'(uo_out), 32'h01);
        chk("reset uio_out", 32'(uio_out), 32'h00);
        chk("reset uio_oe", 32'(uio_oe), 32'h00);

        // Start held high across reset release must not launch a frame.
        uio_in[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uo_out[1] !== 1'b0 || uo_out[2] !== 1'b0) errs++;
        end
        chk("held start after reset", errs, 0);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            start_frame(vecs[v].d, vecs[v].sel, vecs[v].pen);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_bits, vecs[v].nbits,
                        vecs[v].sel, vecs[v].raise_at);
            @(negedge clk);
            chk($sformatf("vec%0d done one cycle", v), 32'(uo_out[2:0]), 32'h1);
            if (vecs[v].raise_at >= 0) begin
                errs = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (uo_out[1] !== 1'b0) errs++;
                end
                chk($sformatf("vec%0d no second frame", v), errs, 0);
                uio_in[0] = 1'b0;
            end
            repeat (4) @(negedge clk);
        end

        // Back-to-back: second start accepted at the edge that ends the DONE cycle.
        start_frame(8'hA5, 3'd0, 1'b0);
        check_frame("b2b first", 11'h34A, 10, 3'd0, 38);
        ui_in       = 8'h3C;
        uio_in[4:1] = 4'b0000;
        check_frame("b2b second", 11'h278, 10, 3'd0, -1);
        @(negedge clk);
        chk("b2b done one cycle", 32'(uo_out[2:0]), 32'h1);
        repeat (4) @(negedge clk);

        // Reset during data bit 3 (TXD low) aborts at once with no DONE.
        start_frame(8'hA5, 3'd0, 1'b0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 2) uio_in[0] = 1'b0;
        end
        chk("pre-reset txd data bit3", 32'(uo_out[2:0]), 32'h2);
        #1;
        rst_n     = 1'b0;
        uio_in[0] = 1'b1;
        #1;
        chk("async reset mid-frame", 32'(uo_out[2:0]), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (uo_out[2:0] !== 3'b001) errs++;
        end
        chk("no done/frame after abort", errs, 0);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_nasser_hadi_serial_tx.md
TT_UM_NASSER_HADI_SERIAL_TX -- requirements
Module: tt_um_nasser_hadi_serial_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the only clock and rst_n is the reset, fixed as such.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design-enable from the harness; ignored by the logic.
REQ-005 ui_in  input  8  transmit data byte, sampled at frame acceptance.
REQ-006 uio_in  input  8  [0] start request (asynchronous level); [3:1] baud select SEL; [4] parity enable PEN; [7:5] unused.
REQ-007 uo_out  output  8  [0] TXD serial line; [1] BUSY; [2] DONE pulse; [7:3] constant 0.
REQ-008 uio_out  output  8  constant 0.
REQ-009 uio_oe  output  8  constant 0, so all uio pins are inputs.

Function
REQ-010 uio_in[0] SHALL pass through a 2-flop synchronizer plus one history flop; a start is detected when stage2=1 and history=0.
REQ-011 Start timing: a rising edge first sampled at clock edge k SHALL be accepted at edge k+2, with TXD low from edge k+2.
REQ-012 At acceptance, ui_in, SEL and PEN SHALL be captured; later input changes SHALL NOT affect the frame in flight.
REQ-013 Bit period SHALL be (4 << SEL) clocks, giving 4..512 clocks; a 9-bit tick counter reloads at each bit boundary.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 FSM transitions SHALL be: IDLE->START on an accepted start; START->DATA after 1 period; DATA->PARITY (PEN=1) or DATA->STOP (PEN=0) after 8 periods; PARITY->STOP after 1 period; STOP->IDLE after 1 period.
REQ-016 TXD value per state SHALL be: IDLE=1, START=0, DATA=data bits LSB first, PARITY=even parity (XOR of the 8 data bits), STOP=1.
REQ-017 BUSY SHALL be 1 in every state except IDLE; TXD, BUSY and DONE SHALL be registered outputs.
REQ-018 DONE SHALL be high for exactly one clock, the cycle in which the FSM re-enters IDLE.
REQ-019 Frame length SHALL be 10 periods (PEN=0) or 11 periods (PEN=1).
REQ-020 A start edge detected while BUSY=1 SHALL be discarded and never queued.
REQ-021 Back-to-back frames: a start edge accepted in the cycle DONE is high SHALL start a new frame, with no minimum idle gap beyond the synchronizer latency.
REQ-022 The bit counter SHALL be 3 bits and wrap from 7 only on leaving DATA.

Reset
REQ-023 While rst_n=0, the outputs SHALL be TXD=1, BUSY=0 and DONE=0, with the FSM in IDLE and all counters at 0, all asynchronously.
REQ-024 All synchronizer and history flops SHALL reset to 1, so a start held high through reset release does not launch a frame.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with TXD=1, and no DONE SHALL be issued for the aborted frame.

Structure
REQ-026 Package tt_serial_tx_pkg SHALL hold the state enum, BAUD_BASE=4, DATA_BITS=8 and the SEL width.
REQ-027 One sub-module, serial_tx_baud_gen, SHALL own the period counter and emit a one-cycle bit_tick; it takes clk, rst_n, a restart input and the captured SEL.
REQ-028 The top SHALL instantiate serial_tx_baud_gen once; the FSM, shift register and synchronizer live in the top.

Verification
REQ-029 Basic frame: ui_in=0xA5, SEL=0, PEN=0, start edge at k -> TXD 0,1,0,1,0,0,1,0,1,1 at 4 clocks each from k+2, BUSY high 40 clocks, DONE one cycle at k+42.
REQ-030 Even parity: ui_in=0x07, SEL=1, PEN=1 -> 11 periods of 8 clocks each, with the parity period TXD=1; ui_in=0xA5 -> parity period TXD=0.
REQ-031 Busy rejection: second start edge at frame midpoint -> exactly one frame transmitted, no second BUSY assertion.
REQ-032 Reset mid-frame: rst_n low during DATA bit 3 -> TXD=1 and BUSY=0 within the same cycle, no DONE; start held high through release -> no frame.
REQ-033 Data stability: ui_in changed from 0xA5 to 0x00 one cycle after acceptance -> transmitted bits still 0xA5; SEL=7 -> each bit lasts 512 clocks.
REQ-034 Back-to-back frames: start re-toggled so acceptance coincides with the DONE cycle -> second START begins at that edge, with TXD showing one stop period then immediately 0.
